// File: rtl/id_ex_stage_reg_pkg.sv
// Shared pipeline definitions for the dual-lane datapath.
// Holds the register/data widths, the ID/EX stage state encoding, the
// hard-wired zero register index and the lane control bundle that the
// EX/MEM stage reuses.
package id_ex_stage_reg_pkg;

  localparam int REG_W  = 3;
  localparam int DATA_W = 16;

  // Register 0 is hard-wired to zero, so a load targeting it never creates a hazard.
  localparam logic [REG_W-1:0] R0 = 3'd0;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    BUBBLE = 2'd1,
    HOLD   = 2'd2
  } stage_state_e;

  // Lane-1 (ALU) and lane-2 (load/store) control bits travelling together.
  typedef struct packed {
    logic alu_src_b;
    logic reg_write1;
    logic reg_write2;
    logic mem_read2;
    logic mem_write2;
  } ctrl_t;

endpackage

// File: rtl/id_ex_stage_reg_load_use_detect.sv
// Load-use hazard detector (purely combinational).
// Flags when the load now in ID/EX writes a register that the instruction
// pair in IF/ID actually reads.
// Ports: if_id_* decoded source fields and selects of the waiting pair,
//        id_ex_* lane-2 load information, load_use hazard flag.
module load_use_detect
  import id_ex_stage_reg_pkg::*;
#(
  parameter int AW = id_ex_stage_reg_pkg::REG_W
) (
  input  logic [AW-1:0] if_id_rm_1,
  input  logic [AW-1:0] if_id_rd_11,
  input  logic [AW-1:0] if_id_rd_12,
  input  logic          if_id_alu_src_b,
  input  logic [AW-1:0] if_id_rm_2,
  input  logic [AW-1:0] if_id_rn_2,
  input  logic [AW-1:0] if_id_rd_2,
  input  logic          if_id_mem_write2,
  input  logic          if_id_valid,
  input  logic          id_ex_valid,
  input  logic          id_ex_mem_read2,
  input  logic [AW-1:0] id_ex_rd_2,
  output logic          load_use
);

  logic [AW-1:0] b_src_s;
  logic          match_s;

  // Only the B operand that the ALU mux will really select can cause a hazard.
  assign b_src_s = if_id_alu_src_b ? if_id_rd_12 : if_id_rd_11;

  // A store reads its rd_2 as the data to write, so it counts as a source only for stores.
  assign match_s = (if_id_rm_1 == id_ex_rd_2) |
                   (b_src_s    == id_ex_rd_2) |
                   (if_id_rm_2 == id_ex_rd_2) |
                   (if_id_rn_2 == id_ex_rd_2) |
                   (if_id_mem_write2 & (if_id_rd_2 == id_ex_rd_2));

  assign load_use = id_ex_valid & id_ex_mem_read2 & (id_ex_rd_2 != AW'(R0)) &
                    if_id_valid & match_s;

endmodule

// File: rtl/id_ex_stage_reg.sv
// Dual-lane ID/EX pipeline register with load-use hazard control.
// Lane 1 is ALU, lane 2 is load/store. Inserts one bubble on a load-use
// hazard, holds while data memory is busy and squashes on a taken branch.
// Ports: IF_ID_* fields/controls/operands in, ID_EX_* registered copies out,
//        flush and mem_busy control in, stall (combinational) and a
//        saturating stall_count of bubble-insert cycles out.
module id_ex_stage_reg #(
  parameter int REG_W  = id_ex_stage_reg_pkg::REG_W,
  parameter int DATA_W = id_ex_stage_reg_pkg::DATA_W,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [REG_W-1:0]  IF_ID_rm_1,
  input  logic [REG_W-1:0]  IF_ID_rd_11,
  input  logic [REG_W-1:0]  IF_ID_rd_12,
  input  logic              IF_ID_ALUSrcB,
  input  logic              IF_ID_RegWrite1,
  input  logic [REG_W-1:0]  IF_ID_rm_2,
  input  logic [REG_W-1:0]  IF_ID_rn_2,
  input  logic [REG_W-1:0]  IF_ID_rd_2,
  input  logic              IF_ID_MemRead2,
  input  logic              IF_ID_MemWrite2,
  input  logic              IF_ID_RegWrite2,
  input  logic [DATA_W-1:0] IF_ID_opA1,
  input  logic [DATA_W-1:0] IF_ID_opB1,
  input  logic [DATA_W-1:0] IF_ID_opA2,
  input  logic [DATA_W-1:0] IF_ID_opB2,
  input  logic              IF_ID_valid,
  input  logic              flush,
  input  logic              mem_busy,
  output logic [REG_W-1:0]  ID_EX_rm_1,
  output logic [REG_W-1:0]  ID_EX_rd_11,
  output logic [REG_W-1:0]  ID_EX_rd_12,
  output logic [REG_W-1:0]  ID_EX_rm_2,
  output logic [REG_W-1:0]  ID_EX_rn_2,
  output logic [REG_W-1:0]  ID_EX_rd_2,
  output logic              ID_EX_ALUSrcB,
  output logic              ID_EX_RegWrite1,
  output logic              ID_EX_RegWrite2,
  output logic              ID_EX_MemRead2,
  output logic              ID_EX_MemWrite2,
  output logic [DATA_W-1:0] ID_EX_opA1,
  output logic [DATA_W-1:0] ID_EX_opB1,
  output logic [DATA_W-1:0] ID_EX_opA2,
  output logic [DATA_W-1:0] ID_EX_opB2,
  output logic              ID_EX_valid,
  output logic              stall,
  output logic [CNT_W-1:0]  stall_count
);

  import id_ex_stage_reg_pkg::*;

  typedef enum logic [1:0] {
    LOAD_NORMAL = 2'd0,
    LOAD_BUBBLE = 2'd1,
    LOAD_HOLD   = 2'd2,
    LOAD_ZERO   = 2'd3
  } load_sel_e;

  stage_state_e state_r, next_state_s;
  load_sel_e    load_sel_s;
  logic         stall_s;
  logic         cnt_inc_s;
  logic         load_use_s;
  logic         bubble_s;
  ctrl_t        if_id_ctrl_s;

  assign if_id_ctrl_s = '{alu_src_b:  IF_ID_ALUSrcB,
                          reg_write1: IF_ID_RegWrite1,
                          reg_write2: IF_ID_RegWrite2,
                          mem_read2:  IF_ID_MemRead2,
                          mem_write2: IF_ID_MemWrite2};

  load_use_detect #(.AW(REG_W)) u_load_use_detect (
    .if_id_rm_1      (IF_ID_rm_1),
    .if_id_rd_11     (IF_ID_rd_11),
    .if_id_rd_12     (IF_ID_rd_12),
    .if_id_alu_src_b (if_id_ctrl_s.alu_src_b),
    .if_id_rm_2      (IF_ID_rm_2),
    .if_id_rn_2      (IF_ID_rn_2),
    .if_id_rd_2      (IF_ID_rd_2),
    .if_id_mem_write2(if_id_ctrl_s.mem_write2),
    .if_id_valid     (IF_ID_valid),
    .id_ex_valid     (ID_EX_valid),
    .id_ex_mem_read2 (ID_EX_MemRead2),
    .id_ex_rd_2      (ID_EX_rd_2),
    .load_use        (load_use_s)
  );

  // Next-state, load selection and stall decision: flush > mem_busy > load_use > load.
  always_comb begin
    next_state_s = RUN;
    load_sel_s   = LOAD_NORMAL;
    stall_s      = 1'b0;
    cnt_inc_s    = 1'b0;
    if (flush) begin
      load_sel_s   = LOAD_ZERO;
      next_state_s = RUN;
    end else if (mem_busy) begin
      load_sel_s   = LOAD_HOLD;
      next_state_s = HOLD;
      stall_s      = 1'b1;
    end else begin
      case (state_r)
        BUBBLE: begin
          load_sel_s   = LOAD_NORMAL;
          next_state_s = RUN;
        end
        // Leaving HOLD re-evaluates the hazard in the same cycle, exactly like RUN.
        RUN, HOLD: begin
          if (load_use_s) begin
            load_sel_s   = LOAD_BUBBLE;
            next_state_s = BUBBLE;
            stall_s      = 1'b1;
            cnt_inc_s    = 1'b1;
          end else begin
            load_sel_s   = LOAD_NORMAL;
            next_state_s = RUN;
          end
        end
        default: begin
          load_sel_s   = LOAD_NORMAL;
          next_state_s = RUN;
        end
      endcase
    end
  end

  // Stall is forced low during reset so upstream stages are never frozen by a stale mem_busy.
  assign stall    = rst_n & stall_s;
  assign bubble_s = (load_sel_s == LOAD_BUBBLE);

  // Stage state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= RUN;
    end else begin
      state_r <= next_state_s;
    end
  end

  // ID/EX pipeline register; a bubble keeps addresses/data so forwarding compares stay harmless.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      {ID_EX_rm_1, ID_EX_rd_11, ID_EX_rd_12, ID_EX_rm_2, ID_EX_rn_2, ID_EX_rd_2} <= '0;
      {ID_EX_ALUSrcB, ID_EX_RegWrite1, ID_EX_RegWrite2}                          <= 3'b000;
      {ID_EX_MemRead2, ID_EX_MemWrite2, ID_EX_valid}                             <= 3'b000;
      {ID_EX_opA1, ID_EX_opB1, ID_EX_opA2, ID_EX_opB2}                           <= '0;
    end else begin
      case (load_sel_s)
        LOAD_ZERO: begin
          {ID_EX_rm_1, ID_EX_rd_11, ID_EX_rd_12, ID_EX_rm_2, ID_EX_rn_2, ID_EX_rd_2} <= '0;
          {ID_EX_ALUSrcB, ID_EX_RegWrite1, ID_EX_RegWrite2}                          <= 3'b000;
          {ID_EX_MemRead2, ID_EX_MemWrite2, ID_EX_valid}                             <= 3'b000;
          {ID_EX_opA1, ID_EX_opB1, ID_EX_opA2, ID_EX_opB2}                           <= '0;
        end
        LOAD_HOLD: begin
          ID_EX_valid <= ID_EX_valid;
        end
        LOAD_NORMAL, LOAD_BUBBLE: begin
          ID_EX_rm_1      <= IF_ID_rm_1;
          ID_EX_rd_11     <= IF_ID_rd_11;
          ID_EX_rd_12     <= IF_ID_rd_12;
          ID_EX_rm_2      <= IF_ID_rm_2;
          ID_EX_rn_2      <= IF_ID_rn_2;
          ID_EX_rd_2      <= IF_ID_rd_2;
          ID_EX_ALUSrcB   <= if_id_ctrl_s.alu_src_b;
          ID_EX_RegWrite1 <= if_id_ctrl_s.reg_write1 & ~bubble_s;
          ID_EX_RegWrite2 <= if_id_ctrl_s.reg_write2 & ~bubble_s;
          ID_EX_MemRead2  <= if_id_ctrl_s.mem_read2  & ~bubble_s;
          ID_EX_MemWrite2 <= if_id_ctrl_s.mem_write2 & ~bubble_s;
          ID_EX_valid     <= IF_ID_valid & ~bubble_s;
          ID_EX_opA1      <= IF_ID_opA1;
          ID_EX_opB1      <= IF_ID_opB1;
          ID_EX_opA2      <= IF_ID_opA2;
          ID_EX_opB2      <= IF_ID_opB2;
        end
        default: begin
          ID_EX_valid <= 1'b0;
        end
      endcase
    end
  end

  // Saturating count of bubble-insert cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_count <= '0;
    end else if (cnt_inc_s && (stall_count != {CNT_W{1'b1}})) begin
      stall_count <= stall_count + CNT_W'(1);
    end else begin
      stall_count <= stall_count;
    end
  end

endmodule

// File: tb/tb_id_ex_stage_reg.sv
module tb_id_ex_stage_reg;

  typedef struct packed {
    logic [2:0]  rm1, rd11, rd12;
    logic        alusrcb, rw1;
    logic [2:0]  rm2, rn2, rd2;
    logic        mr2, mw2, rw2;
    logic [15:0] opa1, opb1, opa2, opb2;
    logic        valid;
  } st_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  logic mem_busy = 1'b0;
  st_t  drv = '0;
  st_t  obs;

  logic [2:0]  o_rm1, o_rd11, o_rd12, o_rm2, o_rn2, o_rd2;
  logic        o_alusrcb, o_rw1, o_rw2, o_mr2, o_mw2, o_valid, stall;
  logic [15:0] o_opa1, o_opb1, o_opa2, o_opb2, stall_count;

  logic [2:0]  b_rm1, b_rd11, b_rd12, b_rm2, b_rn2, b_rd2;
  logic        b_alusrcb, b_rw1, b_rw2, b_mr2, b_mw2, b_valid, b_stall;
  logic [15:0] b_opa1, b_opb1, b_opa2, b_opb2;
  logic [1:0]  sat_count;

  // Reference model state
  st_t exp_q = '0;
  int  exp_cnt = 0;
  int  exp_sat = 0;
  bit  exp_stall, obs_stall;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  assign obs = '{rm1: o_rm1, rd11: o_rd11, rd12: o_rd12, alusrcb: o_alusrcb, rw1: o_rw1,
                 rm2: o_rm2, rn2: o_rn2, rd2: o_rd2, mr2: o_mr2, mw2: o_mw2, rw2: o_rw2,
                 opa1: o_opa1, opb1: o_opb1, opa2: o_opa2, opb2: o_opb2, valid: o_valid};

  id_ex_stage_reg dut (
    .clk(clk), .rst_n(rst_n),
    .IF_ID_rm_1(drv.rm1), .IF_ID_rd_11(drv.rd11), .IF_ID_rd_12(drv.rd12),
    .IF_ID_ALUSrcB(drv.alusrcb), .IF_ID_RegWrite1(drv.rw1),
    .IF_ID_rm_2(drv.rm2), .IF_ID_rn_2(drv.rn2), .IF_ID_rd_2(drv.rd2),
    .IF_ID_MemRead2(drv.mr2), .IF_ID_MemWrite2(drv.mw2), .IF_ID_RegWrite2(drv.rw2),
    .IF_ID_opA1(drv.opa1), .IF_ID_opB1(drv.opb1), .IF_ID_opA2(drv.opa2), .IF_ID_opB2(drv.opb2),
    .IF_ID_valid(drv.valid), .flush(flush), .mem_busy(mem_busy),
    .ID_EX_rm_1(o_rm1), .ID_EX_rd_11(o_rd11), .ID_EX_rd_12(o_rd12),
    .ID_EX_rm_2(o_rm2), .ID_EX_rn_2(o_rn2), .ID_EX_rd_2(o_rd2),
    .ID_EX_ALUSrcB(o_alusrcb), .ID_EX_RegWrite1(o_rw1), .ID_EX_RegWrite2(o_rw2),
    .ID_EX_MemRead2(o_mr2), .ID_EX_MemWrite2(o_mw2),
    .ID_EX_opA1(o_opa1), .ID_EX_opB1(o_opb1), .ID_EX_opA2(o_opa2), .ID_EX_opB2(o_opb2),
    .ID_EX_valid(o_valid), .stall(stall), .stall_count(stall_count)
  );

  id_ex_stage_reg #(.CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n),
    .IF_ID_rm_1(drv.rm1), .IF_ID_rd_11(drv.rd11), .IF_ID_rd_12(drv.rd12),
    .IF_ID_ALUSrcB(drv.alusrcb), .IF_ID_RegWrite1(drv.rw1),
    .IF_ID_rm_2(drv.rm2), .IF_ID_rn_2(drv.rn2), .IF_ID_rd_2(drv.rd2),
    .IF_ID_MemRead2(drv.mr2), .IF_ID_MemWrite2(drv.mw2), .IF_ID_RegWrite2(drv.rw2),
    .IF_ID_opA1(drv.opa1), .IF_ID_opB1(drv.opb1), .IF_ID_opA2(drv.opa2), .IF_ID_opB2(drv.opb2),
    .IF_ID_valid(drv.valid), .flush(flush), .mem_busy(mem_busy),
    .ID_EX_rm_1(b_rm1), .ID_EX_rd_11(b_rd11), .ID_EX_rd_12(b_rd12),
    .ID_EX_rm_2(b_rm2), .ID_EX_rn_2(b_rn2), .ID_EX_rd_2(b_rd2),
    .ID_EX_ALUSrcB(b_alusrcb), .ID_EX_RegWrite1(b_rw1), .ID_EX_RegWrite2(b_rw2),
    .ID_EX_MemRead2(b_mr2), .ID_EX_MemWrite2(b_mw2),
    .ID_EX_opA1(b_opa1), .ID_EX_opB1(b_opb1), .ID_EX_opA2(b_opa2), .ID_EX_opB2(b_opb2),
    .ID_EX_valid(b_valid), .stall(b_stall), .stall_count(sat_count)
  );

  function automatic st_t rand_st();
    st_t s;
    s.rm1 = 3'($urandom_range(0, 7));  s.rd11 = 3'($urandom_range(0, 7));
    s.rd12 = 3'($urandom_range(0, 7)); s.alusrcb = 1'($urandom_range(0, 1));
    s.rw1 = 1'($urandom_range(0, 1));  s.rm2 = 3'($urandom_range(0, 7));
    s.rn2 = 3'($urandom_range(0, 7));  s.rd2 = 3'($urandom_range(0, 7));
    s.mr2 = 1'($urandom_range(0, 1));  s.mw2 = 1'($urandom_range(0, 1));
    s.rw2 = 1'($urandom_range(0, 1));
    s.opa1 = 16'($urandom); s.opb1 = 16'($urandom);
    s.opa2 = 16'($urandom); s.opb2 = 16'($urandom);
    s.valid = 1'($urandom_range(0, 1));
    return s;
  endfunction

  // Hazard rule: the load in ID/EX writes a register the valid IF/ID pair reads.
  function automatic bit model_load_use();
    logic [2:0] r;
    logic [2:0] bsrc;
    r = exp_q.rd2;
    bsrc = drv.alusrcb ? drv.rd12 : drv.rd11;
    if (!(exp_q.valid && exp_q.mr2 && (r != 3'd0) && drv.valid)) return 1'b0;
    return (drv.rm1 == r) || (bsrc == r) || (drv.rm2 == r) || (drv.rn2 == r) ||
           (drv.mw2 && (drv.rd2 == r));
  endfunction

  function automatic void model_reset();
    exp_q = '0;
    exp_cnt = 0;
    exp_sat = 0;
  endfunction

  // One clock: sample stall mid-cycle, then apply the edge to the model.
  task automatic step();
    bit lu;
    @(negedge clk);
    lu = model_load_use();
    obs_stall = stall;
    exp_stall = flush ? 1'b0 : (mem_busy ? 1'b1 : lu);
    @(posedge clk);
    if (flush) begin
      exp_q = '0;
    end else if (mem_busy) begin
      exp_q = exp_q;
    end else if (lu) begin
      exp_q = drv;
      exp_q.rw1 = 1'b0; exp_q.rw2 = 1'b0; exp_q.mr2 = 1'b0; exp_q.mw2 = 1'b0;
      exp_q.valid = 1'b0;
      exp_cnt++;
      if (exp_sat < 3) exp_sat++;
    end else begin
      exp_q = drv;
    end
    #1;
  endtask

  task automatic test_reset();
    drv = rand_st();
    mem_busy = 1'b1;
    flush = 1'b0;
    model_reset();
    #3;
    n_vec++; if (stall !== 1'b0) begin n_err++; $display("FAIL reset_stall got %b want 0", stall); end
    n_vec++; if (obs !== st_t'(0)) begin n_err++; $display("FAIL reset_stage got %h want 0", obs); end
    n_vec++; if (stall_count !== 16'd0 || sat_count !== 2'd0) begin
      n_err++; $display("FAIL reset_count got %0d/%0d want 0/0", stall_count, sat_count); end
    repeat (2) @(posedge clk);
    mem_busy = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_normal_flow();
    drv = '0;
    drv.rm1 = 3'd3; drv.opa1 = 16'h1234; drv.valid = 1'b1;
    step();
    n_vec++; if (obs_stall !== 1'b0) begin n_err++; $display("FAIL normal_stall got %b want 0", obs_stall); end
    n_vec++; if (o_rm1 !== 3'd3 || o_opa1 !== 16'h1234 || o_valid !== 1'b1) begin
      n_err++; $display("FAIL normal_load got rm1=%0d opA1=%h valid=%b want 3 1234 1", o_rm1, o_opa1, o_valid); end
    n_vec++; if (obs !== exp_q) begin n_err++; $display("FAIL normal_stage got %h want %h", obs, exp_q); end
  endtask

  task automatic test_load_use();
    st_t b;
    drv = '0; drv.mr2 = 1'b1; drv.rd2 = 3'd5; drv.rw2 = 1'b1; drv.valid = 1'b1;
    step();
    b = rand_st();
    b.rm1 = 3'd5; b.rw1 = 1'b1; b.valid = 1'b1;
    drv = b;
    step();
    n_vec++; if (obs_stall !== 1'b1) begin n_err++; $display("FAIL lu_stall got %b want 1", obs_stall); end
    n_vec++; if (o_rw1 !== 1'b0 || o_valid !== 1'b0 || stall_count !== 16'd1) begin
      n_err++; $display("FAIL lu_bubble got rw1=%b valid=%b cnt=%0d want 0 0 1", o_rw1, o_valid, stall_count); end
    n_vec++; if (obs !== exp_q) begin n_err++; $display("FAIL lu_bubble_stage got %h want %h", obs, exp_q); end
    step();
    n_vec++; if (obs_stall !== 1'b0) begin n_err++; $display("FAIL lu_after_stall got %b want 0", obs_stall); end
    n_vec++; if (obs !== b || stall_count !== 16'd1) begin
      n_err++; $display("FAIL lu_reload got %h cnt=%0d want %h cnt=1", obs, stall_count, b); end
  endtask

  task automatic test_no_hazard();
    int c0;
    c0 = exp_cnt;
    drv = '0; drv.mr2 = 1'b1; drv.rd2 = 3'd0; drv.valid = 1'b1;
    step();
    drv = '0; drv.valid = 1'b1;
    step();
    n_vec++; if (obs_stall !== 1'b0 || stall_count !== 16'(c0)) begin
      n_err++; $display("FAIL nohaz_r0 got stall=%b cnt=%0d want 0 %0d", obs_stall, stall_count, c0); end
    drv = '0; drv.mr2 = 1'b1; drv.rd2 = 3'd6; drv.valid = 1'b1;
    step();
    drv = '0; drv.rm1 = 3'd1; drv.rm2 = 3'd2; drv.rn2 = 3'd3; drv.alusrcb = 1'b1;
    drv.rd11 = 3'd6; drv.rd12 = 3'd2; drv.rd2 = 3'd6; drv.mw2 = 1'b0; drv.valid = 1'b1;
    step();
    n_vec++; if (obs_stall !== 1'b0 || stall_count !== 16'(c0)) begin
      n_err++; $display("FAIL nohaz_sel got stall=%b cnt=%0d want 0 %0d", obs_stall, stall_count, c0); end
    n_vec++; if (obs !== exp_q) begin n_err++; $display("FAIL nohaz_stage got %h want %h", obs, exp_q); end
  endtask

  task automatic test_mem_busy();
    st_t a;
    a = rand_st(); a.mr2 = 1'b0; a.valid = 1'b1;
    drv = a;
    step();
    mem_busy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drv = rand_st();
      step();
      n_vec++; if (obs_stall !== 1'b1 || obs !== a) begin
        n_err++; $display("FAIL busy_hold%0d got stall=%b %h want 1 %h", i, obs_stall, obs, a); end
    end
    mem_busy = 1'b0;
    drv = rand_st(); drv.valid = 1'b1;
    step();
    n_vec++; if (obs_stall !== 1'b0 || obs !== drv) begin
      n_err++; $display("FAIL busy_release got stall=%b %h want 0 %h", obs_stall, obs, drv); end
  endtask

  task automatic test_flush_load_use();
    int c0;
    drv = rand_st(); drv.mr2 = 1'b1; drv.rd2 = 3'd4; drv.valid = 1'b1;
    step();
    c0 = exp_cnt;
    drv = rand_st(); drv.rm1 = 3'd4; drv.valid = 1'b1;
    flush = 1'b1;
    step();
    flush = 1'b0;
    n_vec++; if (obs_stall !== 1'b0 || obs !== st_t'(0) || stall_count !== 16'(c0)) begin
      n_err++; $display("FAIL flush_lu got stall=%b %h cnt=%0d want 0 0 %0d", obs_stall, obs, stall_count, c0); end
    drv = rand_st(); drv.valid = 1'b1;
    step();
    mem_busy = 1'b1;
    step();
    flush = 1'b1;
    step();
    flush = 1'b0; mem_busy = 1'b0;
    n_vec++; if (obs_stall !== 1'b0 || obs !== st_t'(0)) begin
      n_err++; $display("FAIL flush_hold got stall=%b %h want 0 0", obs_stall, obs); end
  endtask

  task automatic test_saturation();
    int c0;
    c0 = exp_cnt;
    for (int i = 0; i < 5; i++) begin
      drv = rand_st(); drv.mr2 = 1'b1; drv.rd2 = 3'd1; drv.valid = 1'b1;
      step();
      drv = rand_st(); drv.rm1 = 3'd1; drv.mr2 = 1'b0; drv.valid = 1'b1;
      step();
    end
    n_vec++; if (sat_count !== 2'd3) begin n_err++; $display("FAIL sat_count got %0d want 3", sat_count); end
    n_vec++; if (stall_count !== 16'(c0 + 5)) begin
      n_err++; $display("FAIL wide_count got %0d want %0d", stall_count, c0 + 5); end
  endtask

  task automatic test_reset_mid();
    drv = rand_st(); drv.mr2 = 1'b1; drv.rd2 = 3'd2; drv.valid = 1'b1;
    step();
    drv = rand_st(); drv.rn2 = 3'd2; drv.valid = 1'b1;
    step();
    rst_n = 1'b0;
    model_reset();
    #2;
    n_vec++; if (obs !== st_t'(0) || stall_count !== 16'd0) begin
      n_err++; $display("FAIL rst_bubble got %h cnt=%0d want 0 0", obs, stall_count); end
    @(negedge clk); rst_n = 1'b1;
    drv = rand_st(); drv.valid = 1'b1;
    step();
    mem_busy = 1'b1;
    step(); step();
    rst_n = 1'b0;
    model_reset();
    mem_busy = 1'b0;
    #2;
    n_vec++; if (obs !== st_t'(0) || stall !== 1'b0) begin
      n_err++; $display("FAIL rst_hold got %h stall=%b want 0 0", obs, stall); end
    @(negedge clk); rst_n = 1'b1;
    drv = rand_st(); drv.valid = 1'b1;
    step();
    n_vec++; if (obs_stall !== 1'b0 || obs !== drv) begin
      n_err++; $display("FAIL rst_resume got stall=%b %h want 0 %h", obs_stall, obs, drv); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      drv = rand_st();
      flush = ($urandom_range(0, 9) == 0);
      mem_busy = ($urandom_range(0, 4) == 0);
      step();
      n_vec++; if (obs_stall !== exp_stall) begin
        n_err++; $display("FAIL rnd_stall[%0d] got %b want %b", i, obs_stall, exp_stall); end
      n_vec++; if (obs !== exp_q) begin
        n_err++; $display("FAIL rnd_stage[%0d] got %h want %h", i, obs, exp_q); end
      n_vec++; if (stall_count !== 16'(exp_cnt) || sat_count !== 2'(exp_sat)) begin
        n_err++; $display("FAIL rnd_count[%0d] got %0d/%0d want %0d/%0d", i, stall_count, sat_count, exp_cnt, exp_sat); end
    end
    flush = 1'b0;
    mem_busy = 1'b0;
  endtask

  initial begin
    test_reset();
    test_normal_flow();
    test_load_use();
    test_no_hazard();
    test_mem_busy();
    test_flush_load_use();
    test_saturation();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/id_ex_stage_reg.md
Name: id_ex_stage_reg

Overview:
Dual-lane ID/EX pipeline register. Lane 1 is ALU, lane 2 is load/store. It also contains the load-use hazard controller that sits directly upstream of the forwarding unit. Its registered ID_EX_* outputs are the register-address and control inputs that forwarding consumes. It raises stall toward PC/IF-ID, inserts bubbles, holds during memory wait and flushes on branch.

Parameters:
REG_W, 3, register address width
DATA_W, 16, operand data width
CNT_W, 16, stall performance counter width

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
IF_ID_rm_1, IF_ID_rd_11, IF_ID_rd_12  in  REG_W each  lane-1 decoded source/dest fields
IF_ID_ALUSrcB  in  1  lane-1 B-operand select (0: rd_11, 1: rd_12)
IF_ID_RegWrite1  in  1  lane-1 writes register
IF_ID_rm_2, IF_ID_rn_2, IF_ID_rd_2  in  REG_W each  lane-2 fields
IF_ID_MemRead2, IF_ID_MemWrite2, IF_ID_RegWrite2  in  1 each  lane-2 controls
IF_ID_opA1, IF_ID_opB1, IF_ID_opA2, IF_ID_opB2  in  DATA_W each  register-file read data
IF_ID_valid  in  1  IF/ID holds a real instruction pair
flush  in  1  branch-taken squash
mem_busy  in  1  data memory not ready; whole pipe must hold
ID_EX_rm_1, ID_EX_rd_11, ID_EX_rd_12, ID_EX_rm_2, ID_EX_rn_2, ID_EX_rd_2  out  REG_W each  registered fields
ID_EX_ALUSrcB, ID_EX_RegWrite1, ID_EX_RegWrite2, ID_EX_MemRead2, ID_EX_MemWrite2  out  1 each  registered controls
ID_EX_opA1, ID_EX_opB1, ID_EX_opA2, ID_EX_opB2  out  DATA_W each  registered operands
ID_EX_valid  out  1  stage holds a real instruction
stall  out  1  combinational; freeze PC and IF/ID this cycle
stall_count  out  CNT_W  saturating count of bubble-insert cycles

Behaviour:
- Reset (rst_n=0, async): all outputs 0, state RUN, stall_count 0. stall is 0 while in reset.
- load_use (combinational) is asserted when all of these hold:
  - ID_EX_valid and ID_EX_MemRead2 are set, and ID_EX_rd_2 != 0.
  - ID_EX_rd_2 matches any of: IF_ID_rm_1; IF_ID_rd_11 when ALUSrcB=0; IF_ID_rd_12 when ALUSrcB=1; IF_ID_rm_2; IF_ID_rn_2; IF_ID_rd_2 when MemWrite2.
  - IF_ID_valid is set.
- States: RUN, BUBBLE, HOLD.
- Priority per edge: flush > mem_busy > load_use > normal load.
  - flush: the edge clears every control bit and valid (addresses/data go to 0). Next state is RUN. stall=0.
  - mem_busy: all ID_EX_* registers hold. stall=1. State goes to HOLD, and stays HOLD while mem_busy=1. When mem_busy deasserts, returns to RUN and re-evaluates load_use in that same cycle.
  - load_use in RUN: stall=1. The edge loads a bubble: RegWrite1/2, MemRead2, MemWrite2 and valid cleared; address and data fields loaded from IF_ID so forwarding compares stay harmless. State goes to BUBBLE and stall_count increments, saturating at all-ones.
  - BUBBLE: stall=0. Normal load, then RUN. BUBBLE cannot re-trigger because the bubble has MemRead2=0.
  - normal load: every field is copied from IF_ID. ID_EX_valid gets IF_ID_valid.
- Latency: one cycle, IF_ID to ID_EX.
- Simultaneous events:
  - flush with load_use: flush wins, no stall, no count.
  - flush during HOLD: flush wins, bubble loaded even though mem_busy=1.
- Reset mid-HOLD or mid-BUBBLE returns to RUN with a cleared stage.
- stall is a pure function of state and inputs. It is never registered.

Decomposition:
- Shared pipeline package holds:
  - REG_W/DATA_W constants;
  - state enum {RUN, BUBBLE, HOLD};
  - R0 constant 3'd0;
  - a struct for the lane-1 and lane-2 control bundle, reused by EX/MEM.
- One natural sub-module: load_use_detect, purely combinational, taking IF_ID fields and ID_EX lane-2 fields and producing load_use.

Test Plan:
- Reset then normal flow: load IF_ID_rm_1=3, opA1=16'h1234, valid=1. The next edge gives ID_EX_rm_1=3, ID_EX_opA1=16'h1234, ID_EX_valid=1, stall=0.
- Load-use: ID_EX holds MemRead2=1, rd_2=5; IF_ID_rm_1=5. Required: stall=1 that cycle; next edge gives ID_EX_RegWrite1=0, valid=0, stall_count=1; the following edge loads the real instruction with stall=0.
- No hazard on R0 or inactive select: ID_EX rd_2=0 with MemRead2=1, or rd_11 match while ALUSrcB=1 (rd_12 differing), gives stall=0 and no count.
- mem_busy held 3 cycles: ID_EX_* unchanged for 3 edges and stall=1 throughout. On release, load resumes.
- Flush coinciding with load_use: next edge gives all controls 0 and valid 0, stall=0, stall_count unchanged.
- Counter saturation with CNT_W=2: 5 load-use events leave stall_count=3.
